// File: rtl/hdc_pkg.sv
// Shared types and arithmetic helpers for the hyperdimensional classifier.
package hdc_pkg;

    typedef enum logic {
        MODE_TRAIN   = 1'b0,
        MODE_PREDICT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Widest hypervector the popcount helper handles; narrower vectors are zero-extended.
    localparam int POP_MAX = 4096;

    function automatic int popcount(input logic [POP_MAX-1:0] v);
        int acc;
        acc = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            acc = acc + int'(v[i]);
        end
        return acc;
    endfunction

    // Strict majority: an exact tie on an even population resolves to 0.
    function automatic logic majority(input int count, input int n);
        return (2 * count > n);
    endfunction

endpackage

// File: rtl/hdc_classifier_if.sv
// Feature-beat input and prediction result bundle of the classifier.
interface hdc_classifier_if
    import hdc_pkg::*;
#(
    parameter int DIM    = 1024,
    parameter int CLS_DW = 4
);
    logic [DIM-1:0]    im_value;
    logic [DIM-1:0]    im_pos;
    logic              smp_en;
    mode_e             mode;
    logic [CLS_DW-1:0] label;
    logic              busy;
    logic [CLS_DW-1:0] predict;
    logic              pred_hit;
    logic              pred_valid;

    modport master (
        output im_value, im_pos, smp_en, mode, label,
        input  busy, predict, pred_hit, pred_valid
    );

    modport slave (
        input  im_value, im_pos, smp_en, mode, label,
        output busy, predict, pred_hit, pred_valid
    );
endinterface

// File: rtl/hd_bundler.sv
// Per-bit majority bundler over N enabled input vectors; enc/done are valid in
// the cycle of the N-th enabled beat so the caller can register them directly.
module hd_bundler
    import hdc_pkg::*;
#(
    parameter int DIM = 1024,
    parameter int N   = 784
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clear,
    input  logic [DIM-1:0] data,
    output logic [DIM-1:0] enc,
    output logic           done
);
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt [DIM];
    logic [CW-1:0] beats;
    logic          last;

    assign last = (beats == CW'(N - 1));
    assign done = en && last && !clear;

    // The final beat is folded in combinationally so the result needs no extra cycle.
    always_comb begin
        enc = '0;
        for (int i = 0; i < DIM; i++) begin
            enc[i] = majority(int'(cnt[i]) + int'(data[i]), N);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats <= '0;
            for (int i = 0; i < DIM; i++) begin
                cnt[i] <= '0;
            end
        end else if (clear || done) begin
            beats <= '0;
            for (int i = 0; i < DIM; i++) begin
                cnt[i] <= '0;
            end
        end else if (en) begin
            beats <= beats + 1'b1;
            for (int i = 0; i < DIM; i++) begin
                cnt[i] <= cnt[i] + CW'(data[i]);
            end
        end
    end

endmodule

// File: rtl/hdc_classifier.sv
// Hyperdimensional classifier: bind + spatial bundle per sample, temporal bundle
// into class prototypes (TRAIN), sequential arg-max Hamming scan of the AM (PREDICT).
module hdc_classifier
    import hdc_pkg::*;
#(
    parameter int DIM      = 1024,
    parameter int CLS_NUM  = 10,
    parameter int SMP_SIZE = 784,
    parameter int SET_SIZE = 16,
    parameter int CLS_DW   = $clog2(CLS_NUM)
) (
    input logic              clk,
    input logic              rst_n,
    input logic              clear,
    hdc_classifier_if.slave  io
);
    localparam int SIM_W = $clog2(DIM + 1);

    logic [DIM-1:0]    bound_p0;
    logic              accept_p0;
    logic [DIM-1:0]    smp_enc_p0;
    logic              smp_fin_p0;
    logic [DIM-1:0]    smp_vec_p1;
    logic              smp_done_p1;
    logic              train_evt;
    logic              predict_evt;
    logic              temporal_clr;
    logic [DIM-1:0]    proto_enc;
    logic              proto_fin;
    logic              label_ok;
    logic [DIM-1:0]    am [CLS_NUM];
    logic [CLS_NUM-1:0] am_vld;
    logic [DIM-1:0]    query_p2;
    fsm_e              state;
    logic [CLS_DW-1:0] scan_idx;
    logic              scan_last;
    logic [DIM-1:0]    am_rd;
    logic [SIM_W-1:0]  sim_p2;
    logic [SIM_W-1:0]  best_sim;
    logic [CLS_DW-1:0] best_idx;
    logic              best_hit;
    logic [SIM_W-1:0]  nxt_sim;
    logic [CLS_DW-1:0] nxt_idx;
    logic              nxt_hit;

    // Stage p0: bind and spatial bundling of accepted beats
    assign accept_p0 = io.smp_en && !io.busy;
    assign bound_p0  = io.im_value ^ io.im_pos;

    hd_bundler #(.DIM(DIM), .N(SMP_SIZE)) u_spatial (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept_p0),
        .clear (clear),
        .data  (bound_p0),
        .enc   (smp_enc_p0),
        .done  (smp_fin_p0)
    );

    // Stage p1: registered sample vector and its done strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_done_p1 <= 1'b0;
        end else begin
            smp_done_p1 <= smp_fin_p0 && !clear;
        end
    end

    always_ff @(posedge clk) begin
        if (smp_fin_p0) begin
            smp_vec_p1 <= smp_enc_p0;
        end
    end

    assign train_evt    = smp_done_p1 && (io.mode == MODE_TRAIN);
    assign predict_evt  = smp_done_p1 && (io.mode == MODE_PREDICT) && !clear;
    // A predict sample throws away any partially accumulated training set.
    assign temporal_clr = clear || (smp_done_p1 && (io.mode == MODE_PREDICT));

    hd_bundler #(.DIM(DIM), .N(SET_SIZE)) u_temporal (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (train_evt),
        .clear (temporal_clr),
        .data  (smp_vec_p1),
        .enc   (proto_enc),
        .done  (proto_fin)
    );

    assign label_ok = ({1'b0, io.label} < (CLS_DW + 1)'(CLS_NUM));

    always_ff @(posedge clk) begin
        if (proto_fin && label_ok) begin
            am[io.label] <= proto_enc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am_vld <= '0;
        end else if (proto_fin && label_ok) begin
            am_vld[io.label] <= 1'b1;
        end
    end

    // Stage p2: query capture and one-class-per-cycle similarity scan
    always_ff @(posedge clk) begin
        if (predict_evt && (state == IDLE)) begin
            query_p2 <= smp_vec_p1;
        end
    end

    assign am_rd     = am[scan_idx];
    assign sim_p2    = SIM_W'(DIM - popcount(POP_MAX'(am_rd ^ query_p2)));
    assign scan_last = (scan_idx == CLS_DW'(CLS_NUM - 1));

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        nxt_sim = best_sim;
        nxt_idx = best_idx;
        nxt_hit = best_hit;
        if (am_vld[scan_idx] && (!best_hit || (sim_p2 > best_sim))) begin
            nxt_sim = sim_p2;
            nxt_idx = scan_idx;
            nxt_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == SCAN) begin
            best_sim <= nxt_sim;
            best_idx <= nxt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            scan_idx      <= '0;
            best_hit      <= 1'b0;
            io.busy       <= 1'b0;
            io.predict    <= '0;
            io.pred_hit   <= 1'b0;
            io.pred_valid <= 1'b0;
        end else if (clear) begin
            state         <= IDLE;
            scan_idx      <= '0;
            best_hit      <= 1'b0;
            io.busy       <= 1'b0;
            io.pred_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    io.pred_valid <= 1'b0;
                    if (predict_evt) begin
                        state    <= SCAN;
                        io.busy  <= 1'b1;
                        scan_idx <= '0;
                        best_hit <= 1'b0;
                    end
                end
                SCAN: begin
                    best_hit <= nxt_hit;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        state         <= DONE;
                        scan_idx      <= '0;
                        io.predict    <= nxt_hit ? nxt_idx : '0;
                        io.pred_hit   <= nxt_hit;
                        io.pred_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    io.busy       <= 1'b0;
                    io.pred_valid <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    io.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_classifier.sv
// Bench for hdc_classifier (DIM=16, CLS_NUM=4, SMP_SIZE=3, SET_SIZE=1) with a
// bit-counting majority / arg-max reference model.
module tb_hdc_classifier;
    import hdc_pkg::*;

    localparam int DIM = 16;
    localparam int CLS = 4;
    localparam int SMP = 3;
    localparam int LAT = 2 + CLS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    hdc_classifier_if #(.DIM(DIM), .CLS_DW(2)) io ();

    hdc_classifier #(.DIM(DIM), .CLS_NUM(CLS), .SMP_SIZE(SMP), .SET_SIZE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    logic [DIM-1:0] m_am [CLS];
    logic [CLS-1:0] m_vld;

    typedef struct {
        logic [3:0]           mask;
        logic [3:0][DIM-1:0]  proto;
        logic [DIM-1:0]       query;
        logic [1:0]           exp_pred;
        logic                 exp_hit;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DIM-1:0] bundle3(input logic [DIM-1:0] a, b, c);
        logic [DIM-1:0] r;
        int cnt;
        for (int i = 0; i < DIM; i++) begin
            cnt = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (2 * cnt > SMP);
        end
        return r;
    endfunction

    task automatic model_predict(input logic [DIM-1:0] q, output logic [1:0] p, output logic h);
        int best;
        int s;
        p = 2'd0;
        h = 1'b0;
        best = -1;
        for (int c = 0; c < CLS; c++) begin
            if (m_vld[c]) begin
                s = DIM - $countones(m_am[c] ^ q);
                if (s > best) begin
                    best = s;
                    p = 2'(c);
                    h = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        io.smp_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_vld = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DIM-1:0] b, input bit gap);
        logic [DIM-1:0] r;
        if (gap) begin
            io.smp_en = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        r = DIM'($urandom);
        io.im_value = r;
        io.im_pos = r ^ b;
        io.smp_en = 1'b1;
        @(posedge clk);
        #1;
        io.smp_en = 1'b0;
    endtask

    task automatic send_sample(input logic [DIM-1:0] b0, b1, b2, input bit gaps);
        beat(b0, gaps);
        beat(b1, gaps);
        beat(b2, gaps);
    endtask

    task automatic train(input logic [1:0] lbl, input logic [DIM-1:0] b0, b1, b2, input bit gaps);
        io.mode = MODE_TRAIN;
        io.label = lbl;
        send_sample(b0, b1, b2, gaps);
        @(posedge clk);
        #1;
        m_am[lbl] = bundle3(b0, b1, b2);
        m_vld[lbl] = 1'b1;
    endtask

    task automatic run_predict(input string name, input logic [DIM-1:0] b0, b1, b2,
                               input bit gaps, input bit junk,
                               input logic [1:0] exp_pred, input logic exp_hit);
        int got;
        bit busy_ok;
        io.mode = MODE_PREDICT;
        send_sample(b0, b1, b2, gaps);
        check({name, " busy@t+1"}, 32'(io.busy), 32'd0);
        got = 0;
        busy_ok = 1'b1;
        for (int k = 2; k <= 12; k++) begin
            if (junk && k == 3) begin
                io.im_value = DIM'($urandom);
                io.im_pos = DIM'($urandom);
                io.smp_en = 1'b1;
            end
            @(posedge clk);
            #1;
            io.smp_en = 1'b0;
            if (io.busy !== 1'b1) busy_ok = 1'b0;
            if (io.pred_valid === 1'b1) begin
                got = k;
                break;
            end
        end
        check({name, " valid_cycle"}, 32'(got), 32'(LAT));
        check({name, " busy_span"}, 32'(busy_ok), 32'd1);
        check({name, " predict"}, 32'(io.predict), 32'(exp_pred));
        check({name, " pred_hit"}, 32'(io.pred_hit), 32'(exp_hit));
        @(posedge clk);
        #1;
        check({name, " idle_after"}, 32'({io.busy, io.pred_valid}), 32'd0);
    endtask

    initial begin
        logic [1:0] mp;
        logic mh;
        logic [DIM-1:0] q;
        int pulses;

        io.im_value = '0;
        io.im_pos = '0;
        io.smp_en = 1'b0;
        io.mode = MODE_TRAIN;
        io.label = '0;
        m_vld = '0;

        tbl[0] = '{4'b1111, {16'hFFFF, 16'h0FFF, 16'h00FF, 16'h0000}, 16'h0FFF, 2'd2, 1'b1};
        tbl[1] = '{4'b0011, {16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA}, 16'hAAAA, 2'd0, 1'b1};
        tbl[2] = '{4'b1000, {16'h1234, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 2'd3, 1'b1};
        tbl[3] = '{4'b1111, {16'hFFFF, 16'h0FFF, 16'h00FF, 16'h0000}, 16'hF0FF, 2'd1, 1'b1};
        tbl[4] = '{4'b0110, {16'h0000, 16'h00FF, 16'hFF00, 16'h0000}, 16'h0001, 2'd2, 1'b1};

        // Reset state and empty-AM prediction
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset outputs", 32'({io.busy, io.predict, io.pred_hit, io.pred_valid}), 32'd0);
        run_predict("empty_am", 16'h1111, 16'h2222, 16'h4444, 1'b0, 1'b0, 2'd0, 1'b0);

        // Majority on both the training and the query path
        do_reset();
        train(2'd0, 16'h0FF7, 16'h0FF7, 16'h0FF7, 1'b0);
        train(2'd2, 16'hFFFF, 16'h00FF, 16'h0F0F, 1'b0);
        run_predict("maj_q0FFF", 16'h0FFF, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 2'd2, 1'b1);
        run_predict("maj_q0FF7", 16'h0FF7, 16'h0FF7, 16'h0FF7, 1'b0, 1'b0, 2'd0, 1'b1);
        run_predict("maj_query", 16'hFFFF, 16'h00FF, 16'h0F0F, 1'b1, 1'b0, 2'd2, 1'b1);

        // Table-driven argmax / tie / sparse-AM vectors
        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int c = 0; c < CLS; c++) begin
                if (tbl[i].mask[c]) begin
                    train(2'(c), tbl[i].proto[c], tbl[i].proto[c], tbl[i].proto[c], bit'(i % 2));
                end
            end
            run_predict($sformatf("tbl%0d", i), tbl[i].query, tbl[i].query, tbl[i].query,
                        bit'(i % 2), bit'(i == 3), tbl[i].exp_pred, tbl[i].exp_hit);
            if (i == 3) begin
                run_predict("after_junk", 16'h0FFF, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 2'd2, 1'b1);
            end
        end

        // clear mid-sample discards the partial beats
        do_reset();
        train(2'd0, 16'h00F0, 16'h00F0, 16'h00F0, 1'b0);
        io.mode = MODE_TRAIN;
        io.label = 2'd1;
        beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        train(2'd1, 16'h0F00, 16'h0F00, 16'h0F00, 1'b0);
        run_predict("clear_mid", 16'h0F00, 16'h0F00, 16'h0F00, 1'b0, 1'b0, 2'd1, 1'b1);

        // Reset during a scan
        do_reset();
        train(2'd3, 16'h1234, 16'h1234, 16'h1234, 1'b0);
        run_predict("pre_rst", 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0, 2'd3, 1'b1);
        io.mode = MODE_PREDICT;
        send_sample(16'h1234, 16'h1234, 16'h1234, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("scan busy", 32'(io.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_scan outputs", 32'({io.busy, io.predict, io.pred_hit, io.pred_valid}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_vld = '0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (io.pred_valid === 1'b1) pulses++;
        end
        check("rst_mid_scan no_valid", 32'(pulses), 32'd0);
        run_predict("rst_am_cleared", 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0, 2'd0, 1'b0);

        // Randomized train/predict mix against the model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            logic [DIM-1:0] b0, b1, b2;
            b0 = DIM'($urandom);
            b1 = DIM'($urandom);
            b2 = DIM'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                train(2'($urandom_range(0, 3)), b0, b1, b2, bit'($urandom_range(0, 1)));
            end else begin
                if (m_vld != '0 && $urandom_range(0, 1) == 1) begin
                    q = m_am[$urandom_range(0, 3)] ^ (DIM'(1) << $urandom_range(0, DIM - 1));
                    b0 = q;
                    b1 = q;
                    b2 = q;
                end
                model_predict(bundle3(b0, b1, b2), mp, mh);
                run_predict($sformatf("rand%0d", it), b0, b1, b2,
                            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), mp, mh);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hdc_classifier.md
# hdc_classifier

Parametrised hyperdimensional classifier: binds position/value item-memory vectors, bundles them into a sample hypervector by per-bit majority, and in TRAIN mode bundles a set of samples into a class prototype stored in an on-chip associative memory (AM). In PREDICT mode it scans all `CLS_NUM` prototypes sequentially and returns the arg-max Hamming-similarity class with a valid strobe. It sits between the item-memory lookup and the system controller, and replaces the fixed two-class top.

## Interface
- `DIM`, 1024: hypervector width in bits.
- `CLS_NUM`, 10: number of classes (≥2).
- `SMP_SIZE`, 784: bound features per sample.
- `SET_SIZE`, 16: samples per training set.
- `CLS_DW`, `$clog2(CLS_NUM)`: label/predict width (derived).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous abort; zeroes bundlers, counters and the FSM; AM untouched.
- `im_value` in DIM: value hypervector.
- `im_pos` in DIM: position hypervector.
- `smp_en` in 1: feature beat valid.
- `mode` in 1: `MODE_TRAIN`=0, `MODE_PREDICT`=1.
- `label` in CLS_DW: training class.
- `busy` out 1: high during SCAN/DONE; beats are ignored while high.
- `predict` out CLS_DW: winning class.
- `pred_hit` out 1: at least one trained class was compared.
- `pred_valid` out 1: one-cycle result strobe.

## Operation
- Bind: `im_value ^ im_pos` on every accepted beat (`smp_en && !busy`).
- Spatial bundler: per-bit counters of width `$clog2(SMP_SIZE+1)`. After `SMP_SIZE` beats, bit = 1 iff `2*count > SMP_SIZE`; a tie on even sizes gives 0. Counters clear on the same cycle, and `smp_done` pulses.
- `mode` is sampled at `smp_done`. Changing it mid-sample has no other effect.
- TRAIN: the sample feeds the temporal bundler (same majority rule, `SET_SIZE`). On the `SET_SIZE`-th sample, `label` is sampled, then `AM[label]` is written and `am_vld[label]` set. Retraining a class overwrites it.
- An out-of-range label (≥`CLS_NUM`) writes nothing.
- PREDICT: the sample hypervector is registered as the query, and any partial training set is discarded (temporal counters cleared).
- FSM states and transitions:
  - IDLE → SCAN on a PREDICT `smp_done`.
  - SCAN: one class per cycle, index 0..`CLS_NUM`-1. Similarity = `DIM - popcount(AM[i] ^ query)`, width `$clog2(DIM+1)`. Classes with `am_vld`=0 are skipped. The best is replaced only on strictly greater similarity, so the lowest index wins ties.
  - SCAN → DONE after the last index.
  - DONE: drive `predict`/`pred_hit`, pulse `pred_valid`, → IDLE.
- No class trained: `predict`=0, `pred_hit`=0, `pred_valid` still pulses.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - all counters 0;
  - `am_vld` all 0.
  - AM contents need no reset because `am_vld` gates them.
- `clear` has priority over every other event in the same cycle, including a same-cycle `smp_done`.

## Timing
- Last beat of a sample at cycle t → `smp_done` and sample vector registered at t+1.
- TRAIN: AM write visible at t+2. A predict whose scan starts at or after t+2 sees the new prototype.
- PREDICT: `busy` high from t+2 through t+2+`CLS_NUM`. `pred_valid` at t+2+`CLS_NUM`. `predict` holds until the next `pred_valid`.
- Beats can be non-consecutive. Gaps in `smp_en` stall the counters without loss.
- Back-to-back samples in TRAIN need no gap. In PREDICT the next sample's beats may start once `busy` falls.
- Reset mid-scan: outputs return to 0 immediately, and no `pred_valid` is issued.

## Structure
- `hdc_pkg`:
  - `mode_e`;
  - `fsm_e` (IDLE, SCAN, DONE);
  - a `popcount` function;
  - a majority-threshold helper.
- Sub-module `hd_bundler` (params `DIM`, `N`; ports `en`, `clear`, `data`, `enc`, `done`), instantiated twice (spatial, temporal).
- AM: a `CLS_NUM`×`DIM` register array with a single write port and a single indexed read port. The read is combinational into a registered similarity stage.

## Test plan
Bench configuration: `DIM`=16, `CLS_NUM`=4, `SMP_SIZE`=3, `SET_SIZE`=1.
- Majority: beats with bound vectors 0xFFFF, 0x00FF, 0x0F0F → sample 0x0FFF. Train label 2 → `AM[2]`=0x0FFF.
- Argmax: train classes 0..3 with 0x0000, 0x00FF, 0x0FFF, 0xFFFF, then predict query 0x0FFF → `predict`=2, `pred_hit`=1, `pred_valid` at t+6.
- Tie: classes 0 and 1 both 0xAAAA, query 0xAAAA → `predict`=0.
- Empty AM: predict right after reset → `pred_valid`=1, `pred_hit`=0, `predict`=0. Only class 3 trained → `predict`=3.
- Handshake: `smp_en` pulsed while `busy` → ignored; result unchanged and the next sample count starts at 0. Gapped beats give the same result as contiguous beats.
- Abort:
  - `clear` mid-sample → next 3 beats form a fresh sample.
  - `rst_n` low mid-scan → no `pred_valid`, outputs 0, `am_vld` all 0.
